// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for a common-anode seven-segment display: walks the
// digits of a frame-buffered value, blanking at each slot start to avoid ghosting.
module seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_suppress,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_valid_q, pend_valid_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
  logic                blank_q, blank_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_wrap;
  logic                frame_wrap;
  logic [DIGITS-1:0]   nib_zero;
  logic [DIGITS-1:0]   zero_from;
  logic                suppress_d;

  assign slot_wrap  = (cnt_q == CNT_MAX);
  assign frame_wrap = slot_wrap && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the frame edge lands in pending and survives into the next frame,
  // while the previously pending value is the one promoted to active.
  always_comb begin
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    if (frame_wrap && pend_valid_q) begin
      active_d     = pending_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pending_d    = value;
      pend_valid_d = 1'b1;
    end
  end

  // zero_from[k] is set when nibbles k..DIGITS-1 of the next active value are all zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign nib_zero[gi]  = (active_d[4*gi +: 4] == 4'h0);
      assign zero_from[gi] = &nib_zero[DIGITS-1:gi];
    end
  endgenerate

  assign suppress_d = lz_suppress && (idx_d != '0) && zero_from[idx_d];

  always_comb begin
    bcd_d        = active_d[4*idx_d +: 4];
    blank_d      = (cnt_d < BLANK_END);
    frame_done_d = frame_wrap;
    digit_en_n_d = '1;
    if (!blank_d && !suppress_d) begin
      digit_en_n_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      bcd_q        <= 4'h0;
      digit_en_n_q <= '1;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      bcd_q        <= bcd_d;
      digit_en_n_q <= digit_en_n_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd        = bcd_q;
  assign digit_en_n = digit_en_n_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a time-indexed model predicts every cycle's outputs;
// directed steps pin known frames, then random loads, lz toggles and resets.
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        lz_suppress;
  logic [3:0]  bcd;
  logic [3:0]  digit_en_n;
  logic        blank;
  logic        frame_done;

  int total;
  int bad;

  seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .lz_suppress (lz_suppress),
    .bcd         (bcd),
    .digit_en_n  (digit_en_n),
    .blank       (blank),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_t counts cycles since reset release; active is the newest value
  // loaded during the window of edges [E-FRAME, E-1] before frame edge E.
  int          m_t;
  logic [15:0] m_active;
  logic [15:0] m_last_val;
  int          m_last_t;
  logic        m_last_ok;
  logic        m_lz;
  logic        m_started;

  initial m_started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t       = 0;
      m_active  = 16'h0;
      m_last_ok = 1'b0;
      m_last_t  = 0;
      m_last_val = 16'h0;
      m_lz      = 1'b0;
      m_started = 1'b1;
    end else if (m_started) begin
      m_t = m_t + 1;
      if (m_t % FRAME == 0 && m_last_ok && m_last_t >= m_t - FRAME)
        m_active = m_last_val;
      if (load) begin
        m_last_val = value;
        m_last_t   = m_t;
        m_last_ok  = 1'b1;
      end
      m_lz = lz_suppress;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, m_t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      if (!rst_n) begin
        chk("rst_bcd", bcd, 0);
        chk("rst_en", digit_en_n, 4'hF);
        chk("rst_blank", blank, 1);
        chk("rst_fd", frame_done, 0);
      end else begin
        int cnt, idx;
        logic [15:0] upper;
        logic [3:0] e_en;
        logic e_blank, sup;
        cnt     = m_t % DIV;
        idx     = (m_t / DIV) % DIGITS;
        e_blank = (cnt < BLANK);
        upper   = m_active >> (4 * idx);
        sup     = m_lz && idx != 0 && upper == 16'h0;
        e_en    = 4'hF;
        if (!e_blank && !sup) e_en = ~(4'b0001 << idx);
        chk("bcd", bcd, int'(upper[3:0]));
        chk("digit_en_n", digit_en_n, e_en);
        chk("blank", blank, e_blank);
        chk("frame_done", frame_done, (m_t > 0 && m_t % FRAME == 0) ? 1 : 0);
      end
    end
  end

  task automatic go_to(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_t != n && k < 5000);
    if (m_t != n) chk("go_to_timeout", m_t, n);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    #1;
    load  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    load  = 1'b0;
    value = 16'h0;
    lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("lit_c0_en", digit_en_n, 4'hF);
    chk("lit_c0_blank", blank, 1);
    chk("lit_c0_bcd", bcd, 0);
    go_to(2);  chk("lit_c2_en", digit_en_n, 4'hE);
    go_to(8);  chk("lit_c8_blank", blank, 1);
    go_to(31); chk("lit_c31_fd", frame_done, 0);
    go_to(32); chk("lit_c32_fd", frame_done, 1);

    // load mid-frame: takes effect only at the next frame
    go_to(40); do_load(16'h1234);
    go_to(50); chk("lit_still0", bcd, 0);
    go_to(66); chk("lit_1234_d0", bcd, 4); chk("lit_1234_e0", digit_en_n, 4'hE);
    go_to(74); chk("lit_1234_d1", bcd, 3); chk("lit_1234_e1", digit_en_n, 4'hD);
    go_to(82); chk("lit_1234_d2", bcd, 2); chk("lit_1234_e2", digit_en_n, 4'hB);
    go_to(90); chk("lit_1234_d3", bcd, 1); chk("lit_1234_e3", digit_en_n, 4'h7);

    // two loads in one frame: last wins
    go_to(100); do_load(16'hAAAA);
    go_to(110); do_load(16'h0905);
    go_to(130); chk("lit_0905_d0", bcd, 5);
    go_to(138); chk("lit_0905_d1", bcd, 0);
    go_to(146); chk("lit_0905_d2", bcd, 9);
    go_to(154); chk("lit_0905_d3", bcd, 0);

    // leading-zero suppression
    go_to(160); lz_suppress = 1'b1; do_load(16'h0050);
    go_to(194); chk("lit_lz_e0", digit_en_n, 4'hE); chk("lit_lz_d0", bcd, 0);
    go_to(202); chk("lit_lz_e1", digit_en_n, 4'hD); chk("lit_lz_d1", bcd, 5);
    go_to(210); chk("lit_lz_e2", digit_en_n, 4'hF); chk("lit_lz_b2", blank, 0);
    go_to(218); chk("lit_lz_e3", digit_en_n, 4'hF);
    go_to(230); do_load(16'h0000);
    go_to(258); chk("lit_zero_e0", digit_en_n, 4'hE);
    go_to(266); chk("lit_zero_e1", digit_en_n, 4'hF);

    // load coinciding with the frame edge
    go_to(270); do_load(16'h3333);
    go_to(290); chk("lit_3333", bcd, 3);
    go_to(300); lz_suppress = 1'b0; do_load(16'h1111);
    go_to(319); do_load(16'h7777);
    go_to(322); chk("lit_edge_prev", bcd, 1);
    go_to(354); chk("lit_edge_new", bcd, 7);

    // reset mid-slot discards active and pending
    go_to(360); do_load(16'h1234);
    go_to(403);
    chk("lit_pre_rst_bcd", bcd, 2);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_en", digit_en_n, 4'hF);
    chk("lit_rst_blank", blank, 1);
    chk("lit_rst_bcd", bcd, 0);
    chk("lit_rst_fd", frame_done, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    go_to(2);  chk("lit_after_rst_bcd", bcd, 0); chk("lit_after_rst_en", digit_en_n, 4'hE);
    go_to(31); chk("lit_after_rst_fd0", frame_done, 0);
    go_to(32); chk("lit_after_rst_fd1", frame_done, 1);

    // random phase
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0;
      end
      load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0: value = 16'($urandom);
        1: value = 16'($urandom) & 16'h0FFF;
        2: value = 16'($urandom) & 16'h00FF;
        3: value = 16'($urandom) & 16'h000F;
        default: value = 16'h0000;
      endcase
      if ($urandom_range(0, 49) == 0) lz_suppress = ~lz_suppress;
    end
    load  = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
